// File: rtl/mips_defs.sv
// Shared fetch-stage definitions: reset PC, instruction-memory window and the
// layout of one queued fetch entry.
package mips_defs;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF = PC_RESET;
  localparam int          IM_AW_DEF   = 10;
  localparam logic [31:0] NOP         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Misaligned, below the IM window, or at/after base + 4*2^aw.
  function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input int          aw);
    logic [31:0] off;
    off = pc - base;
    return (pc[1:0] != 2'b00) || (pc < base) || ((off >> (aw + 2)) != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy, zeroed head when empty
// and a synchronous clear that overrides push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65
) (
  input  logic                       i_clk,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH+1)-1:0] o_occ,
  output logic                       o_empty,
  output logic [W-1:0]               o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [OW-1:0] r_occ;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign o_empty = (r_occ == {OW{1'b0}});
  assign w_full  = (r_occ == OW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_occ   = r_occ;
  assign o_head  = o_empty ? {W{1'b0}} : r_mem[r_head];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_head <= {PW{1'b0}};
      r_tail <= {PW{1'b0}};
      r_occ  <= {OW{1'b0}};
    end else begin
      r_head <= w_pop  ? ptr_next(r_head) : r_head;
      r_tail <= w_push ? ptr_next(r_tail) : r_tail;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Entry storage; contents are only visible through occupancy, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one synchronous IM read per accepted PC, queues the
// returned {pc, instr, adel} tuples and back-pressures the PC when full.
module instr_fetch_queue
  import mips_defs::*;
#(
  parameter int          DEPTH   = 2,
  parameter int          IM_AW   = IM_AW_DEF,
  parameter logic [31:0] IM_BASE = IM_BASE_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_pc_addr,
  output logic             o_pc_stall,
  input  logic             i_flush,
  output logic             o_im_req,
  output logic [IM_AW-1:0] o_im_addr,
  input  logic [31:0]      i_im_rdata,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_pc,
  output logic [31:0]      o_out_instr,
  output logic             o_out_adel
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = OW + 1;

  logic [OW-1:0] w_occ;
  logic          w_empty;
  logic          w_pop;
  logic          w_bad;
  logic          w_issue;
  logic          w_clear;
  logic [SW-1:0] w_committed;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  logic          r_if_valid;
  logic [31:0]   r_if_pc;
  logic          r_if_bad;

  assign w_pop   = ~w_empty & i_out_ready;
  assign w_bad   = fetch_addr_bad(i_pc_addr, IM_BASE, IM_AW);
  assign w_clear = i_reset | i_flush;

  // Slots already spoken for: queued plus in flight, less the one leaving now.
  assign w_committed = SW'(w_occ) + SW'(r_if_valid) - SW'(w_pop);
  assign w_issue     = ~i_flush & (w_committed < SW'(DEPTH));

  assign o_im_req   = w_issue & ~w_bad;
  assign o_im_addr  = IM_AW'((i_pc_addr - IM_BASE) >> 2);
  assign o_pc_stall = ~w_issue & ~i_flush;

  assign w_push_data.pc    = r_if_pc;
  assign w_push_data.instr = r_if_bad ? NOP : i_im_rdata;
  assign w_push_data.adel  = r_if_bad;

  // In-flight fetch: the PC issued last cycle whose IM data arrives this cycle.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_bad   <= 1'b0;
    end else begin
      r_if_valid <= w_issue;
      r_if_pc    <= i_pc_addr;
      r_if_bad   <= w_bad;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FETCH_ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_clear (w_clear),
    .i_push  (r_if_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign o_out_valid = ~w_empty;
  assign o_out_pc    = w_head.pc;
  assign o_out_instr = w_head.instr;
  assign o_out_adel  = w_head.adel;

endmodule
